// File: rtl/coef_loader.sv
// Serialises NTAPS*WIDTH parallel coefficients into a downstream shift chain,
// driving a two-phase non-overlapping shift clock with one gap cycle on each side.
module coef_loader #(
    parameter int unsigned NTAPS = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   ph1,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [NTAPS*WIDTH-1:0] coefIn,
    output logic                   shiftIn,
    output logic                   shiftClk1,
    output logic                   shiftClk2,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned N    = NTAPS * WIDTH;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(N - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StClk1,
        StGap1,
        StClk2,
        StGap2,
        StFin
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    sreg_q, sreg_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            clk1_q, clk1_d;
    logic            clk2_q, clk2_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sreg_d  = coefIn;
                    cnt_d   = '0;
                    state_d = StSetup;
                end
            end
            StSetup: state_d = StClk1;
            StClk1:  state_d = StGap1;
            StGap1:  state_d = StClk2;
            StClk2:  state_d = StGap2;
            StGap2: begin
                // The last bit is left in place so shiftIn holds it through FIN.
                if (cnt_q == LastBit) begin
                    state_d = StFin;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    sreg_d  = sreg_q << 1;
                    state_d = StSetup;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they are glitch-free
    // and line up exactly with the cycle the FSM spends in each state.
    always_comb begin
        clk1_d = (state_d == StClk1);
        clk2_d = (state_d == StClk2);
        busy_d = (state_d != StIdle);
        done_d = (state_d == StFin);
    end

    always_ff @(posedge ph1 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            sreg_q  <= '0;
            cnt_q   <= '0;
            clk1_q  <= 1'b0;
            clk2_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            clk1_q  <= clk1_d;
            clk2_q  <= clk2_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign shiftIn   = sreg_q[N-1];
    assign shiftClk1 = clk1_q;
    assign shiftClk2 = clk2_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_coef_loader.sv
// Directed bench for coef_loader: timeline model of one load, per-cycle compare,
// and a model of the downstream chain clocked by the DUT's shift clocks.
module tb_coef_loader;

    localparam int N   = 32;
    localparam int LAT = 5 * N + 1;

    logic          ph1 = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [N-1:0]  coefIn = '0;
    logic          shiftIn, shiftClk1, shiftClk2, busy, done;

    coef_loader dut (
        .ph1       (ph1),
        .reset_n   (reset_n),
        .start     (start),
        .coefIn    (coefIn),
        .shiftIn   (shiftIn),
        .shiftClk1 (shiftClk1),
        .shiftClk2 (shiftClk2),
        .busy      (busy),
        .done      (done)
    );

    always #5 ph1 = ~ph1;

    int total = 0;
    int bad = 0;

    // Model: m_t is cycles since the accepting edge (0 = idle); LAT is the done cycle.
    int           m_t = 0;
    logic [N-1:0] m_data = '0;
    logic         m_idle_bit = 1'b0;

    always @(posedge ph1 or negedge reset_n) begin
        if (!reset_n) begin
            m_t        <= 0;
            m_idle_bit <= 1'b0;
        end else if (m_t == 0) begin
            if (start) begin
                m_t    <= 1;
                m_data <= coefIn;
            end
        end else if (m_t == LAT) begin
            m_t        <= 0;
            m_idle_bit <= m_data[0];
        end else begin
            m_t <= m_t + 1;
        end
    end

    logic [N-1:0] chain = '0;
    logic [N-1:0] last_chain = '0;
    int           n_clk1 = 0;
    int           n_clk2 = 0;
    logic         prev_c1 = 1'b0;
    logic         prev_c2 = 1'b0;
    logic         si_at_c1 = 1'b0;
    logic         saw_done = 1'b0;
    int           done_cnt = 0;
    int           idle_run = 0;
    int           last_gap = -1;
    logic         after_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        logic e_busy, e_done, e_c1, e_c2, e_si;
        int   ph, b;
        e_busy = 1'b0;
        e_done = 1'b0;
        e_c1   = 1'b0;
        e_c2   = 1'b0;
        e_si   = m_idle_bit;
        if (m_t == LAT) begin
            e_busy = 1'b1;
            e_done = 1'b1;
            e_si   = m_data[0];
        end else if (m_t != 0) begin
            ph     = (m_t - 1) % 5;
            b      = (m_t - 1) / 5;
            e_busy = 1'b1;
            e_c1   = (ph == 1);
            e_c2   = (ph == 3);
            e_si   = m_data[N-1-b];
        end
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("shiftClk1", shiftClk1, e_c1);
        chk("shiftClk2", shiftClk2, e_c2);
        chk("shiftIn", shiftIn, e_si);
        chk("clk_overlap", shiftClk1 & shiftClk2, 0);
        if (shiftClk1) begin
            chk("clk1_width", prev_c1, 0);
            si_at_c1 = shiftIn;
            chain    = {chain[N-2:0], shiftIn};
            n_clk1++;
        end
        if (shiftClk2) begin
            chk("clk2_width", prev_c2, 0);
            chk("si_stable", shiftIn, si_at_c1);
            n_clk2++;
        end
        prev_c1 = shiftClk1;
        prev_c2 = shiftClk2;
        if (!busy) idle_run++;
        else if (after_done && !done) begin
            last_gap   = idle_run;
            after_done = 1'b0;
        end
        if (done) begin
            chk("chain", chain, m_data);
            chk("n_clk1", 32'(n_clk1), 32'(N));
            chk("n_clk2", 32'(n_clk2), 32'(N));
            last_chain = chain;
            done_cnt++;
            saw_done   = 1'b1;
            n_clk1     = 0;
            n_clk2     = 0;
            after_done = 1'b1;
            idle_run   = 0;
        end
    endtask

    // Compare at the falling edge, then return just after the next rising edge.
    task automatic cycle();
        @(negedge ph1);
        compare();
        @(posedge ph1);
        #1;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!saw_done && k < LAT + 20) begin
            cycle();
            k++;
        end
        chk("done_seen", saw_done, 1);
    endtask

    task automatic load(input logic [N-1:0] data, output int lat);
        coefIn   = data;
        start    = 1'b1;
        saw_done = 1'b0;
        cycle();
        start = 1'b0;
        lat   = 0;
        while (!saw_done && lat < LAT + 20) begin
            cycle();
            lat++;
        end
        chk("done_seen", saw_done, 1);
    endtask

    task automatic run_to(input int t);
        int k;
        k = 0;
        while (m_t != t && k < LAT + 20) begin
            cycle();
            k++;
        end
        chk("reach_t", 32'(m_t), 32'(t));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, d0;
        repeat (3) cycle();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_clk1", shiftClk1, 0);
        chk("rst_clk2", shiftClk2, 0);
        chk("rst_si", shiftIn, 0);
        reset_n = 1'b1;

        // Single load straight after reset release.
        load(32'h0403_0201, lat);
        chk("latency", 32'(lat), 32'd161);
        chk("tap0", last_chain[7:0], 8'h01);
        chk("tap1", last_chain[15:8], 8'h02);
        chk("tap2", last_chain[23:16], 8'h03);
        chk("tap3", last_chain[31:24], 8'h04);
        chk("stream", last_chain, 32'b00000100_00000011_00000010_00000001);
        chk("done_cnt1", 32'(done_cnt), 1);
        repeat (3) cycle();

        // Held start: back-to-back loads, coefIn changed mid-load for the second.
        d0       = done_cnt;
        coefIn   = 32'hFFFF_FFFF;
        start    = 1'b1;
        saw_done = 1'b0;
        cycle();
        coefIn = 32'h0000_0000;
        wait_done();
        chk("ones", last_chain, 32'hFFFF_FFFF);
        saw_done = 1'b0;
        wait_done();
        start = 1'b0;
        chk("zeros", last_chain, 32'h0000_0000);
        chk("gap", 32'(last_gap), 32'd1);
        chk("done_cnt2", 32'(done_cnt - d0), 2);
        repeat (4) cycle();

        // start + new coefIn during bit 10 must not disturb the load.
        d0       = done_cnt;
        coefIn   = 32'h1234_5678;
        start    = 1'b1;
        saw_done = 1'b0;
        cycle();
        start = 1'b0;
        run_to(5 * 10 + 1);
        start  = 1'b1;
        coefIn = 32'hDEAD_BEEF;
        cycle();
        start = 1'b0;
        wait_done();
        chk("no_restart", last_chain, 32'h1234_5678);
        repeat (6) cycle();
        chk("done_cnt3", 32'(done_cnt - d0), 1);

        // Reset during CLK1 of bit 15, then a clean reload.
        d0       = done_cnt;
        coefIn   = 32'h0F0F_00FF;
        start    = 1'b1;
        cycle();
        start = 1'b0;
        run_to(5 * 15 + 2);
        chk("c1_before_rst", shiftClk1, 1);
        reset_n = 1'b0;
        #1;
        chk("arst_clk1", shiftClk1, 0);
        chk("arst_clk2", shiftClk2, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_si", shiftIn, 0);
        chain      = '0;
        n_clk1     = 0;
        n_clk2     = 0;
        prev_c1    = 1'b0;
        prev_c2    = 1'b0;
        after_done = 1'b0;
        repeat (3) cycle();
        reset_n = 1'b1;
        chk("abort_no_done", 32'(done_cnt - d0), 0);
        load(32'hA5A5_5A5A, lat);
        chk("reload", last_chain, 32'hA5A5_5A5A);
        chk("reload_lat", 32'(lat), 32'd161);
        repeat (3) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
